// File: rtl/sfq_tx_pkg.sv
// Shared types and default timing for the SFQ word transmitter.
// State encoding and helper used by sfq_word_tx and its phase counter.
package sfq_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StSetup,
        StClk,
        StGap
    } tx_state_e;

    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefSetupCyc = 2;
    localparam int unsigned DefGapCyc   = 1;
    localparam int unsigned DefMsbFirst = 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sfq_word_tx_if.sv
// Parallel word handshake between conventional logic (master) and the SFQ transmitter (slave).
interface sfq_word_tx_if #(
    parameter int unsigned WIDTH = sfq_tx_pkg::DefWidth
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/sfq_phase_cnt.sv
// Loadable down-counter timing the SETUP and GAP phases; expired_o marks the phase's last cycle.
module sfq_phase_cnt #(
    parameter int unsigned CNT_W = 1
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sfq_word_tx.sv
// Serialises handshaken words into SFQ data-pulse / clock-pulse strobes.
// Define SFQ_TX_PARITY_EN to append an even-parity bit after the data bits.
module sfq_word_tx
    import sfq_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned SETUP_CYC = DefSetupCyc,
    parameter int unsigned GAP_CYC   = DefGapCyc,
    parameter int unsigned MSB_FIRST = DefMsbFirst
) (
    input  logic          clkin,
    input  logic          rst_n,
    sfq_word_tx_if.slave  in_if,
    input  logic          flush,
    output logic          data_pulse,
    output logic          clk_pulse,
    output logic          busy,
    output logic          tx_done
);

`ifdef SFQ_TX_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam int unsigned BitCntW = $clog2(NBITS + 1);
    localparam int unsigned PhW     = $clog2(max_u(SETUP_CYC, GAP_CYC) + 1);
    // Counter holds cycles remaining after the current one, so load length-1.
    localparam logic [PhW-1:0] SetupLoad = PhW'((SETUP_CYC > 1) ? SETUP_CYC - 2 : 0);
    localparam logic [PhW-1:0] GapLoad   = PhW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    tx_state_e          state_q, state_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
    logic               data_pulse_q, clk_pulse_q, busy_q, tx_done_q, in_ready_q;
    logic               data_pulse_d, clk_pulse_d, busy_d, tx_done_d, in_ready_d;

    logic               ph_load, ph_en, ph_clear, ph_expired;
    logic [PhW-1:0]     ph_load_val;

    logic [WIDTH-1:0]   data_ord;
    logic [NBITS-1:0]   load_word;

    // The bit to send is always shift_q[NBITS-1]; bit order is fixed at load time.
    always_comb begin
        data_ord = in_if.in_data;
        if (MSB_FIRST == 0) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                data_ord[i] = in_if.in_data[WIDTH-1-i];
            end
        end
    end

`ifdef SFQ_TX_PARITY_EN
    assign load_word = {data_ord, ^in_if.in_data};
`else
    assign load_word = data_ord;
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        tx_done_d   = 1'b0;
        ph_load     = 1'b0;
        ph_load_val = '0;
        ph_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_if.in_valid && in_ready_q) begin
                    shift_d   = load_word;
                    bit_cnt_d = BitCntW'(NBITS);
                    state_d   = StData;
                end
            end
            StData: begin
                if (SETUP_CYC > 1) begin
                    state_d     = StSetup;
                    ph_load     = 1'b1;
                    ph_load_val = SetupLoad;
                end else begin
                    state_d = StClk;
                end
            end
            StSetup: begin
                if (ph_expired) begin
                    state_d = StClk;
                end else begin
                    ph_en = 1'b1;
                end
            end
            StClk: begin
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q - BitCntW'(1);
                if (GAP_CYC > 0) begin
                    state_d     = StGap;
                    ph_load     = 1'b1;
                    ph_load_val = GapLoad;
                end else if (bit_cnt_q == BitCntW'(1)) begin
                    state_d   = StIdle;
                    tx_done_d = 1'b1;
                end else begin
                    state_d = StData;
                end
            end
            StGap: begin
                if (!ph_expired) begin
                    ph_en = 1'b1;
                end else if (bit_cnt_q == '0) begin
                    state_d   = StIdle;
                    tx_done_d = 1'b1;
                end else begin
                    state_d = StData;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush && (state_q != StIdle)) begin
            state_d   = StIdle;
            shift_d   = '0;
            bit_cnt_d = '0;
            tx_done_d = 1'b0;
            ph_load   = 1'b0;
            ph_en     = 1'b0;
        end

        // Outputs are registered from the next state so they line up with it.
        data_pulse_d = (state_d == StData) && shift_d[NBITS-1];
        clk_pulse_d  = (state_d == StClk);
        busy_d       = (state_d != StIdle);
        in_ready_d   = (state_d == StIdle);
    end

    assign ph_clear = flush && (state_q != StIdle);

    sfq_phase_cnt #(
        .CNT_W (PhW)
    ) u_phase_cnt (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .clear_i    (ph_clear),
        .load_i     (ph_load),
        .load_val_i (ph_load_val),
        .en_i       (ph_en),
        .expired_o  (ph_expired)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            data_pulse_q <= 1'b0;
            clk_pulse_q  <= 1'b0;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            data_pulse_q <= data_pulse_d;
            clk_pulse_q  <= clk_pulse_d;
            busy_q       <= busy_d;
            tx_done_q    <= tx_done_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign data_pulse     = data_pulse_q;
    assign clk_pulse      = clk_pulse_q;
    assign busy           = busy_q;
    assign tx_done        = tx_done_q;
    assign in_if.in_ready = in_ready_q;

endmodule

// File: tb/tb_sfq_word_tx.sv
// Directed bench for sfq_word_tx: pulse timing per cycle after the handshake edge (cycle 1 = DATA).
module tb_sfq_word_tx;

    logic clkin = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic dp_a, cp_a, busy_a, done_a;
    logic dp_b, cp_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    sfq_word_tx_if #(.WIDTH(8)) if_a ();
    sfq_word_tx_if #(.WIDTH(8)) if_b ();

    sfq_word_tx u_dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .in_if      (if_a.slave),
        .flush      (flush),
        .data_pulse (dp_a),
        .clk_pulse  (cp_a),
        .busy       (busy_a),
        .tx_done    (done_a)
    );

    sfq_word_tx #(
        .MSB_FIRST (0)
    ) u_dut_lsb (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .in_if      (if_b.slave),
        .flush      (flush),
        .data_pulse (dp_b),
        .clk_pulse  (cp_b),
        .busy       (busy_b),
        .tx_done    (done_b)
    );

    always #5 clkin = ~clkin;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] train(input int first, input int step, input int n);
        logic [127:0] m = '0;
        for (int i = 0; i < n; i++) m[first + i * step] = 1'b1;
        return m;
    endfunction

    // Records outputs for cycles first..last; caller is already sampling cycle 'first'.
    task automatic capture(input bit sel, input int first, input int last,
                           output logic [127:0] dp, output logic [127:0] cp,
                           output logic [127:0] td, output logic [127:0] rdy);
        dp = '0; cp = '0; td = '0; rdy = '0;
        for (int k = first; k <= last; k++) begin
            dp[k]  = sel ? dp_b : dp_a;
            cp[k]  = sel ? cp_b : cp_a;
            td[k]  = sel ? done_b : done_a;
            rdy[k] = sel ? if_b.in_ready : if_a.in_ready;
            if (k < last) begin
                @(posedge clkin);
                #1;
            end
        end
    endtask

    // Offers a word while idle; returns sampling cycle 1 of that word.
    task automatic start_word(input bit sel, input logic [7:0] w, input bit keep);
        if (sel) begin
            if_b.in_valid = 1'b1;
            if_b.in_data  = w;
        end else begin
            if_a.in_valid = 1'b1;
            if_a.in_data  = w;
        end
        @(posedge clkin);
        #1;
        if (!keep) begin
            if_a.in_valid = 1'b0;
            if_b.in_valid = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] dp, cp, td, rdy, dp2, cp2, td2, rdy2;

        if_a.in_valid = 1'b0;
        if_a.in_data  = '0;
        if_b.in_valid = 1'b0;
        if_b.in_data  = '0;

        #12;
        check_eq("reset_outputs", {123'b0, if_a.in_ready, busy_a, done_a, cp_a, dp_a}, '0);
        #10 rst_n = 1'b1;
        @(posedge clkin);
        #1;
        check_eq("ready_after_reset", {126'b0, if_a.in_ready, if_b.in_ready}, 128'd3);
        check_eq("idle_after_reset", {124'b0, busy_a, busy_b, done_a, done_b}, '0);

        // 8'hA5, MSB first
        start_word(1'b0, 8'hA5, 1'b0);
        capture(1'b0, 1, 33, dp, cp, td, rdy);
        check_eq("a5_data", dp, train(1, 8, 2) | train(21, 8, 2));
        check_eq("a5_clk", cp, train(3, 4, 8));
        check_eq("a5_done", td, train(33, 1, 1));
        check_eq("a5_ready", rdy, train(33, 1, 1));
        idle_cycles(2);

        // 8'h01, LSB first
        start_word(1'b1, 8'h01, 1'b0);
        capture(1'b1, 1, 33, dp, cp, td, rdy);
        check_eq("lsb01_data", dp, train(1, 1, 1));
        check_eq("lsb01_clk", cp, train(3, 4, 8));
        check_eq("lsb01_done", td, train(33, 1, 1));
        idle_cycles(2);

        // 8'h07, MSB first; parity bit (1) trails the data bits when enabled
        start_word(1'b0, 8'h07, 1'b0);
        capture(1'b0, 1, 37, dp, cp, td, rdy);
`ifdef SFQ_TX_PARITY_EN
        check_eq("h07_data", dp, train(21, 4, 4));
        check_eq("h07_clk", cp, train(3, 4, 9));
        check_eq("h07_done", td, train(37, 1, 1));
        check_eq("h07_ready", rdy, train(37, 1, 1));
`else
        check_eq("h07_data", dp, train(21, 4, 3));
        check_eq("h07_clk", cp, train(3, 4, 8));
        check_eq("h07_done", td, train(33, 1, 1));
        check_eq("h07_ready", rdy, train(33, 1, 5));
`endif
        idle_cycles(2);

        // Back-to-back: valid held, 8'hFF then 8'h00 (second handshake ends cycle 33)
        start_word(1'b0, 8'hFF, 1'b1);
        if_a.in_data = 8'h00;
        capture(1'b0, 1, 66, dp, cp, td, rdy);
        if_a.in_valid = 1'b0;
        check_eq("b2b_data", dp, train(1, 4, 8));
        check_eq("b2b_clk", cp, train(3, 4, 8) | train(36, 4, 8));
        check_eq("b2b_done", td, train(33, 1, 1) | train(66, 1, 1));
        check_eq("b2b_ready", rdy, train(33, 1, 1) | train(66, 1, 1));
        idle_cycles(2);

        // Flush raised during cycle 10 of an 8'hFF word
        start_word(1'b0, 8'hFF, 1'b0);
        capture(1'b0, 1, 10, dp, cp, td, rdy);
        check_eq("flush_pre_data", dp, train(1, 4, 3));
        check_eq("flush_pre_clk", cp, train(3, 4, 2));
        flush = 1'b1;
        @(posedge clkin);
        #1;
        flush = 1'b0;
        capture(1'b0, 11, 40, dp2, cp2, td2, rdy2);
        check_eq("flush_no_pulses", dp2 | cp2, '0);
        check_eq("flush_no_done", td2, '0);
        check_eq("flush_ready", rdy2, train(11, 1, 30));
        idle_cycles(1);

        // Asynchronous reset during cycle 12 of an 8'hFF word
        start_word(1'b0, 8'hFF, 1'b0);
        capture(1'b0, 1, 11, dp, cp, td, rdy);
        check_eq("rst_pre_clk", cp, train(3, 4, 3));
        @(posedge clkin);
        #1;
        check_eq("rst_pre_busy", {127'b0, busy_a}, 128'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outputs", {123'b0, if_a.in_ready, busy_a, done_a, cp_a, dp_a}, '0);
        repeat (2) @(posedge clkin);
        #2 rst_n = 1'b1;
        @(posedge clkin);
        #1;
        check_eq("rst_release_ready", {126'b0, if_a.in_ready, busy_a}, 128'd2);
        capture(1'b0, 1, 20, dp, cp, td, rdy);
        check_eq("rst_no_stale", dp | cp | td, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
